// File: rtl/decode_pkg.sv
// decode_pkg: decoded-instruction field layout, format/unit constants and pack helpers.
package decode_pkg;
  localparam int W_FMT = 25, W_OPC = 16, W_ADDR = 64, W_UNIT = 8, W_ID = 32;
  localparam int W_NUOP = 5, W_PID = 64, W_TID = 32, W_BODY = 64;
  localparam int O_BODY = 0;
  localparam int O_MCR = O_BODY + W_BODY;
  localparam int O_ISREG = O_MCR + 1;
  localparam int O_RW = O_ISREG + 4;
  localparam int O_TID = O_RW + 4;
  localparam int O_PID = O_TID + W_TID;
  localparam int O_IS64 = O_PID + W_PID;
  localparam int O_NUOP = O_IS64 + 1;
  localparam int O_MIN = O_NUOP + W_NUOP;
  localparam int O_MAJ = O_MIN + W_ID;
  localparam int O_UNIT = O_MAJ + W_ID;
  localparam int O_ADDR = O_UNIT + W_UNIT;
  localparam int O_OPC = O_ADDR + W_ADDR;
  localparam int O_FMT = O_OPC + W_OPC;
  localparam int ENTRY_W = O_FMT + W_FMT;
  localparam logic [W_FMT-1:0] FMT_I = 25'd1 << 0, FMT_B = 25'd1 << 1, FMT_SC = 25'd1 << 2;
  localparam logic [W_FMT-1:0] FMT_D = 25'd1 << 3, FMT_DS = 25'd1 << 4, FMT_DQ = 25'd1 << 5;
  localparam logic [W_FMT-1:0] FMT_DX = 25'd1 << 6, FMT_X = 25'd1 << 7, FMT_XL = 25'd1 << 8;
  localparam logic [W_FMT-1:0] FMT_XFX = 25'd1 << 9, FMT_XFL = 25'd1 << 10, FMT_XS = 25'd1 << 11;
  localparam logic [W_FMT-1:0] FMT_XO = 25'd1 << 12, FMT_A = 25'd1 << 13, FMT_M = 25'd1 << 14;
  localparam logic [W_FMT-1:0] FMT_MD = 25'd1 << 15, FMT_MDS = 25'd1 << 16, FMT_Z22 = 25'd1 << 17;
  localparam logic [W_FMT-1:0] FMT_Z23 = 25'd1 << 18, FMT_VA = 25'd1 << 19, FMT_VX = 25'd1 << 20;
  localparam logic [W_FMT-1:0] FMT_VXR = 25'd1 << 21, FMT_XX1 = 25'd1 << 22, FMT_XX2 = 25'd1 << 23;
  localparam logic [W_FMT-1:0] FMT_XX3 = 25'd1 << 24;
  typedef enum logic [W_UNIT-1:0] {UNIT_FXU, UNIT_LSU, UNIT_BRU, UNIT_FPU, UNIT_VSU, UNIT_CRU} unit_e;
  function automatic logic [W_ID-1:0] get_maj_id(input logic [ENTRY_W-1:0] e);
    return e[O_MAJ +: W_ID];
  endfunction
  function automatic logic [ENTRY_W-1:0] set_maj_id(input logic [ENTRY_W-1:0] e, input logic [W_ID-1:0] id);
    logic [ENTRY_W-1:0] r;
    r = e;
    r[O_MAJ +: W_ID] = id;
    return r;
  endfunction
endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if: enqueue, dequeue and status signals of the decode queue.
interface decode_queue_if #(
  parameter int DEPTH = 8,
  parameter int ENTRY_W = decode_pkg::ENTRY_W
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  logic enable_i, flush_i, ready_i, valid_o, stall_o, overflow_o;
  logic [ENTRY_W-1:0] entry_i, entry_o;
  logic [CNT_W-1:0] count_o;
  modport slave(
    input enable_i, entry_i, flush_i, ready_i,
    output valid_o, entry_o, stall_o, count_o, overflow_o
  );
  modport master(
    output enable_i, entry_i, flush_i, ready_i,
    input valid_o, entry_o, stall_o, count_o, overflow_o
  );
endinterface

// File: rtl/decode_queue_ram.sv
// decode_queue_ram: DEPTH x ENTRY_W storage, synchronous write, asynchronous read.
module decode_queue_ram #(
  parameter int DEPTH = 8,
  parameter int ENTRY_W = decode_pkg::ENTRY_W
) (
  input  logic                     clock_i,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [ENTRY_W-1:0]       i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [ENTRY_W-1:0]       o_rdata
);
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clock_i)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/decode_queue.sv
// decode_queue: circular FIFO between the decode mux and issue/rename, with
// skid-reserving stall and a sticky overflow flag for dropped enqueues.
module decode_queue #(
  parameter int DEPTH = 8,
  parameter int SKID = 3,
  parameter int ENTRY_W = decode_pkg::ENTRY_W
) (
  input logic           clock_i,
  input logic           reset_i,
  decode_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  logic r_ovf, w_deq, w_full, w_enq, w_drop;
  always_comb begin
    w_deq = (r_count != '0) && bus.ready_i;
    w_full = r_count == CNT_W'(DEPTH);
    w_enq = bus.enable_i && !bus.flush_i && (!w_full || w_deq);
    w_drop = bus.enable_i && !bus.flush_i && !w_enq;
  end
  // flush clears pointers but leaves the sticky overflow flag alone
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_ovf <= 1'b0;
    end else if (bus.flush_i) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      r_head <= r_head + PTR_W'(w_deq);
      r_tail <= r_tail + PTR_W'(w_enq);
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
      r_ovf <= r_ovf | w_drop;
    end
  end
  decode_queue_ram #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) u_ram (
    .clock_i(clock_i),
    .i_we(w_enq && !reset_i),
    .i_waddr(r_tail),
    .i_wdata(bus.entry_i),
    .i_raddr(r_head),
    .o_rdata(bus.entry_o)
  );
  assign bus.valid_o = r_count != '0;
  assign bus.stall_o = r_count >= CNT_W'(DEPTH - SKID);
  assign bus.count_o = r_count;
  assign bus.overflow_o = r_ovf;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed and randomized checks of decode_queue against a queue-based model.
module tb_decode_queue;
  import decode_pkg::*;
  localparam int DEPTH = 8;
  localparam int SKID = 3;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SW = CNT_W + 3;
  logic clock_i = 1'b0;
  logic reset_i;
  int checks = 0;
  int errors = 0;
  logic [ENTRY_W-1:0] mq[$];
  logic [ENTRY_W-1:0] exp_log[$];
  logic [ENTRY_W-1:0] dut_log[$];
  logic m_ovf = 1'b0;
  decode_queue_if #(.DEPTH(DEPTH)) q();
  decode_queue #(.DEPTH(DEPTH), .SKID(SKID)) dut (.clock_i(clock_i), .reset_i(reset_i), .bus(q));
  always #5 clock_i = ~clock_i;

  function automatic logic [ENTRY_W-1:0] mk(input int maj);
    logic [ENTRY_W-1:0] e;
    for (int i = 0; i < ENTRY_W; i += 32) e[i +: 32] = $urandom;
    return set_maj_id(e, maj);
  endfunction

  function automatic logic [SW-1:0] act_status();
    return {q.valid_o, q.stall_o, q.overflow_o, q.count_o};
  endfunction

  function automatic logic [SW-1:0] exp_status();
    return {mq.size() != 0, mq.size() >= DEPTH - SKID, m_ovf, CNT_W'(mq.size())};
  endfunction

  task automatic step(input logic rst, input logic en, input logic fl, input logic rdy, input logic [ENTRY_W-1:0] e);
    logic deq, full;
    reset_i = rst; q.enable_i = en; q.flush_i = fl; q.ready_i = rdy; q.entry_i = e;
    #1;
    if (!rst && !fl && q.valid_o && rdy) dut_log.push_back(q.entry_o);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (fl) mq.delete();
    else begin
      deq = mq.size() > 0 && rdy;
      full = mq.size() == DEPTH;
      if (deq) exp_log.push_back(mq.pop_front());
      if (en && (!full || deq)) mq.push_back(e);
      else if (en) m_ovf = 1'b1;
    end
    @(posedge clock_i);
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 0, 1, mk(0));
    step(1, 0, 0, 0, mk(0));
    checks++;
    if (act_status() !== '0)
      begin errors++; $display("FAIL reset_state: got %h want %h", act_status(), {SW{1'b0}}); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 3; i++) step(0, 1, 0, 0, mk(i));
    checks++;
    if (act_status() !== {1'b1, 1'b0, 1'b0, CNT_W'(3)})
      begin errors++; $display("FAIL three_entries: got %h want %h", act_status(), {1'b1, 1'b0, 1'b0, CNT_W'(3)}); end
    checks++;
    if (get_maj_id(q.entry_o) !== 32'd1)
      begin errors++; $display("FAIL head_maj1: got %0d want 1", get_maj_id(q.entry_o)); end
    step(0, 1, 0, 0, mk(4));
    checks++;
    if (q.stall_o !== 1'b0) begin errors++; $display("FAIL stall_at4: got %b want 0", q.stall_o); end
    step(0, 1, 0, 0, mk(5));
    checks++;
    if (q.stall_o !== 1'b1) begin errors++; $display("FAIL stall_at5: got %b want 1", q.stall_o); end
    for (int i = 6; i <= 8; i++) step(0, 1, 0, 0, mk(i));
    checks++;
    if (act_status() !== {1'b1, 1'b1, 1'b0, CNT_W'(8)})
      begin errors++; $display("FAIL full8: got %h want %h", act_status(), {1'b1, 1'b1, 1'b0, CNT_W'(8)}); end
    step(0, 1, 0, 0, mk(9));
    checks++;
    if (act_status() !== {1'b1, 1'b1, 1'b1, CNT_W'(8)})
      begin errors++; $display("FAIL overflow_drop: got %h want %h", act_status(), {1'b1, 1'b1, 1'b1, CNT_W'(8)}); end
  endtask

  task automatic test_full_simul();
    step(1, 0, 0, 0, mk(0));
    for (int i = 1; i <= 8; i++) step(0, 1, 0, 0, mk(i));
    dut_log.delete();
    step(0, 1, 0, 1, mk(9));
    checks++;
    if (act_status() !== {1'b1, 1'b1, 1'b0, CNT_W'(8)})
      begin errors++; $display("FAIL full_enq_deq: got %h want %h", act_status(), {1'b1, 1'b1, 1'b0, CNT_W'(8)}); end
    checks++;
    if (get_maj_id(q.entry_o) !== 32'd2)
      begin errors++; $display("FAIL full_head2: got %0d want 2", get_maj_id(q.entry_o)); end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, mk(0));
    checks++;
    if (dut_log.size() != 9)
      begin errors++; $display("FAIL full_drain_len: got %0d want 9", dut_log.size()); end
    else for (int i = 0; i < 9; i++) begin
      checks++;
      if (get_maj_id(dut_log[i]) !== 32'(i + 1))
        begin errors++; $display("FAIL full_drain_order[%0d]: got %0d want %0d", i, get_maj_id(dut_log[i]), i + 1); end
    end
  endtask

  task automatic test_stream_wrap();
    int n = 0;
    step(1, 0, 0, 0, mk(0));
    dut_log.delete();
    for (int c = 0; c < 200 && (n < 20 || mq.size() > 0); c++) begin
      if (n < 20 && mq.size() < DEPTH) begin
        step(0, 1, 0, c % 2 == 0, mk(n + 1));
        n++;
      end else step(0, 0, 0, c % 2 == 0, mk(0));
      checks++;
      if (act_status() !== exp_status())
        begin errors++; $display("FAIL stream_status c%0d: got %h want %h", c, act_status(), exp_status()); end
    end
    checks++;
    if (dut_log.size() != 20)
      begin errors++; $display("FAIL stream_len: got %0d want 20", dut_log.size()); end
    else for (int i = 0; i < 20; i++) begin
      checks++;
      if (get_maj_id(dut_log[i]) !== 32'(i + 1))
        begin errors++; $display("FAIL stream_order[%0d]: got %0d want %0d", i, get_maj_id(dut_log[i]), i + 1); end
    end
  endtask

  task automatic test_flush();
    logic [ENTRY_W-1:0] e;
    step(1, 0, 0, 0, mk(0));
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 0, mk(i));
    step(0, 1, 1, 0, mk(99));
    checks++;
    if (act_status() !== '0)
      begin errors++; $display("FAIL flush_clear: got %h want %h", act_status(), {SW{1'b0}}); end
    e = mk(7);
    step(0, 1, 0, 0, e);
    checks++;
    if (act_status() !== {1'b1, 1'b0, 1'b0, CNT_W'(1)})
      begin errors++; $display("FAIL flush_then_enq: got %h want %h", act_status(), {1'b1, 1'b0, 1'b0, CNT_W'(1)}); end
    checks++;
    if (q.entry_o !== e) begin errors++; $display("FAIL flush_then_entry: got %h want %h", q.entry_o, e); end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0, mk(0));
    for (int i = 1; i <= 9; i++) step(0, 1, 0, 0, mk(i));
    step(0, 0, 0, 1, mk(0));
    step(0, 0, 0, 1, mk(0));
    checks++;
    if (act_status() !== {1'b1, 1'b1, 1'b1, CNT_W'(6)})
      begin errors++; $display("FAIL pre_reset: got %h want %h", act_status(), {1'b1, 1'b1, 1'b1, CNT_W'(6)}); end
    step(1, 1, 1, 1, mk(0));
    checks++;
    if (act_status() !== '0)
      begin errors++; $display("FAIL mid_reset: got %h want %h", act_status(), {SW{1'b0}}); end
  endtask

  task automatic test_random();
    step(1, 0, 0, 0, mk(0));
    dut_log.delete();
    exp_log.delete();
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
           1'($urandom_range(0, 1)), mk(c + 100));
      checks++;
      if (act_status() !== exp_status())
        begin errors++; $display("FAIL rand_status c%0d: got %h want %h", c, act_status(), exp_status()); end
      if (mq.size() > 0) begin
        checks++;
        if (q.entry_o !== mq[0])
          begin errors++; $display("FAIL rand_head c%0d: got maj %0d want maj %0d", c, get_maj_id(q.entry_o), get_maj_id(mq[0])); end
      end
    end
    checks++;
    if (dut_log.size() != exp_log.size())
      begin errors++; $display("FAIL rand_deq_len: got %0d want %0d", dut_log.size(), exp_log.size()); end
    else for (int i = 0; i < exp_log.size(); i++) begin
      checks++;
      if (dut_log[i] !== exp_log[i])
        begin errors++; $display("FAIL rand_deq[%0d]: got maj %0d want maj %0d", i, get_maj_id(dut_log[i]), get_maj_id(exp_log[i])); end
    end
  endtask

  initial begin
    reset_i = 1'b1; q.enable_i = 1'b0; q.flush_i = 1'b0; q.ready_i = 1'b0; q.entry_i = '0;
    @(posedge clock_i);
    #1;
    test_reset();
    test_fill_overflow();
    test_full_simul();
    test_stream_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of queue entries (power of 2, minimum 4).
REQ-002 The block SHALL have parameter SKID, default 3, giving the upstream in-flight slots reserved when stall_o asserts.
REQ-003 The block SHALL have parameter ENTRY_W, default 352, giving the packed decoded-instruction width taken from the shared package.
REQ-004 The block SHALL have port clock_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_i, input, 1 bit, a synchronous active-high reset.
REQ-006 The block SHALL have port enable_i, input, 1 bit, enqueue strobe from the decode mux (no backpressure on that side).
REQ-007 The block SHALL have port entry_i, input, ENTRY_W bits, a packed decoded instruction: format, opcode, address, unit, majID, minID, numMicroOps, is64Bit, pid, tid, op1-4 rw, op1-4 isReg, modifiesCR, 64-bit body.
REQ-008 The block SHALL have port flush_i, input, 1 bit, to discard all queued entries.
REQ-009 The block SHALL have port ready_i, input, 1 bit, asserted when the downstream issue/rename stage accepts the head.
REQ-010 The block SHALL have port valid_o, output, 1 bit, asserted when the head entry is valid.
REQ-011 The block SHALL have port entry_o, output, ENTRY_W bits, carrying the head entry.
REQ-012 The block SHALL have port stall_o, output, 1 bit, to hold fetch/decode upstream.
REQ-013 The block SHALL have port count_o, output, log2(DEPTH)+1 bits, carrying the current occupancy.
REQ-014 The block SHALL have port overflow_o, output, 1 bit, a sticky error flag set when an enqueue is dropped.

Function
REQ-015 The queue SHALL be a circular FIFO with head and tail pointers of log2(DEPTH) bits, each wrapping DEPTH-1 -> 0.
REQ-016 Dequeue SHALL occur on a rising edge when valid_o && ready_i; head then advances by 1.
REQ-017 Enqueue SHALL occur on a rising edge when enable_i && !flush_i && (count < DEPTH || dequeue); entry_i is written at tail, and tail advances by 1.
REQ-018 On simultaneous enqueue and dequeue, count SHALL be unchanged, including at count==DEPTH.
REQ-019 When enable_i is high, flush_i is low and the queue is full without a dequeue, the entry SHALL be dropped, overflow_o SHALL set the next cycle, and it SHALL hold until reset.
REQ-020 valid_o SHALL equal (count != 0), and entry_o SHALL equal storage[head] (registered storage, combinational read).
REQ-021 There SHALL be no bypass: an entry enqueued into an empty queue at edge N appears on valid_o/entry_o after edge N and is dequeuable at edge N+1 at the earliest.
REQ-022 stall_o SHALL equal (count >= DEPTH-SKID), evaluated on registered count.
REQ-023 flush_i SHALL take priority over enqueue and dequeue: at the next edge head, tail and count go to 0, and any same-cycle enable_i is dropped without setting overflow_o.
REQ-024 Stored entry bits SHALL pass through unmodified; the block performs no field decoding.
REQ-025 count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-026 While reset_i is high at a rising edge, head, tail and count SHALL clear to 0, overflow_o SHALL clear, valid_o and stall_o SHALL be 0, and enqueue/dequeue SHALL be ignored.
REQ-027 Storage contents SHALL NOT need reset; entry_o SHALL be don't-care while valid_o is 0.
REQ-028 A reset asserted mid-operation SHALL discard all entries exactly as a flush and take priority over flush_i.

Structure
REQ-029 The shared package decode_pkg SHALL hold the field widths, the one-hot format constants (I..XX3, 25 bits), the functional-unit IDs, ENTRY_W, and the per-field bit offsets used to pack and unpack entries.
REQ-030 Storage SHALL be one sub-module, decode_queue_ram: DEPTH x ENTRY_W, one synchronous write port and one asynchronous read port.
REQ-031 Pointer, count and flag logic SHALL reside in decode_queue itself.

Verification
REQ-032 Reset, then enqueue 3 entries with majID 1, 2, 3 and ready_i=0 -> count_o=3, valid_o=1, entry_o majID=1, stall_o=0.
REQ-033 Enqueue 5 entries with ready_i=0 (DEPTH=8, SKID=3) -> stall_o=1 from the cycle count_o=5; fill to 8, then one more enable_i -> dropped, overflow_o=1, count_o=8.
REQ-034 Full queue, enable_i=1 and ready_i=1 in the same cycle -> count_o stays 8, overflow_o stays 0, and the new entry is dequeued last.
REQ-035 Stream 20 entries with ready_i toggling 1,0,1,... -> output majIDs 1..20 in order, with no loss across pointer wrap.
REQ-036 count_o=4 with flush_i=1 and enable_i=1 in the same cycle -> next cycle count_o=0, valid_o=0, overflow_o=0; a following enqueue appears after one edge.
REQ-037 Assert reset_i with count_o=6 and overflow_o=1 -> next cycle count_o=0, overflow_o=0, valid_o=0, stall_o=0.
